// File: rtl/rover_reset_sequencer_pkg.sv
// rover_reset_sequencer_pkg
//   Shared types and constants for the rover reset sequencer.
//   - rstseq_state_t : sequencer FSM states, 3-bit encoding (also exported on seq_state)
//   - RSTSEQ_MAX_STAGES : upper bound on NUM_STAGES
package rover_reset_sequencer_pkg;

    localparam int RSTSEQ_MAX_STAGES = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RELEASE   = 3'd1,
        HOLD      = 3'd2,
        WAIT_RDY  = 3'd3,
        RUN       = 3'd4,
        TEARDOWN  = 3'd5,
        FAULT     = 3'd6
    } rstseq_state_t;

endpackage

// File: rtl/rover_reset_sequencer_lock_filter.sv
// rstseq_lock_filter
//   Consecutive-cycle filter on the PLL lock indication. lock_ok is high once
//   pll_locked has been seen high for LOCK_FILTER_CYC consecutive cycles; any
//   low cycle (or clr) restarts the count. The count saturates.
// Ports
//   clk_100M   in   system clock
//   sysrstn    in   synchronous active-low reset
//   clr        in   restart the count (held while the sequencer is not waiting for lock)
//   pll_locked in   lock indication, already synchronous
//   lock_ok    out  filtered lock
module rstseq_lock_filter #(
    parameter int LOCK_FILTER_CYC = 1024
) (
    input  logic clk_100M,
    input  logic sysrstn,
    input  logic clr,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int CW = $clog2(LOCK_FILTER_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILTER_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !pll_locked) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!sysrstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lock_ok = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rover_reset_sequencer.sv
// rover_reset_sequencer
//   Releases subsystem resets in index order once the clock generator is
//   locked, waiting a fixed delay and then for each stage's ready flag before
//   moving on. Lock loss or a software request tears resets down in reverse
//   order, one released stage per cycle, then the sequence restarts.
//   Optional readiness watchdog: define RSTSEQ_WATCHDOG_EN.
// Ports
//   clk_100M     in   system clock
//   sysrstn      in   synchronous active-low reset
//   pll_locked   in   clock generator lock (synchronous)
//   sw_rst_req   in   one-cycle pulse: tear down and re-sequence / clear fault
//   stage_ready  in   per-stage initialised flags
//   stage_rstn   out  per-stage active-low resets (registered)
//   all_up       out  high only in RUN (registered)
//   fault        out  readiness timeout latched (watchdog builds only)
//   fault_stage  out  stage index that timed out
//   seq_state    out  FSM state for debug
module rover_reset_sequencer
    import rover_reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int LOCK_FILTER_CYC = 1024,
    parameter int STAGE_DELAY_CYC = 1000,
    parameter int WDT_CYC         = 1_000_000
) (
    input  logic                  clk_100M,
    input  logic                  sysrstn,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  all_up,
    output logic                  fault,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] fault_stage,
    output logic [2:0]            seq_state
);

    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int DW = $clog2(STAGE_DELAY_CYC + 1);
    localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);
    // STAGE_DELAY_CYC >= 1: HOLD lasts exactly STAGE_DELAY_CYC cycles
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DELAY_CYC - 1);

    rstseq_state_t         state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         dly_q, dly_d;
    logic [NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                  all_up_q, all_up_d;
    logic                  lock_ok;
    logic                  abort_req;

    rstseq_lock_filter #(
        .LOCK_FILTER_CYC (LOCK_FILTER_CYC)
    ) u_lock_filter (
        .clk_100M   (clk_100M),
        .sysrstn    (sysrstn),
        .clr        (state_q != WAIT_LOCK),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    // A single abort covers lock loss and sw request arriving together.
    assign abort_req = !pll_locked || sw_rst_req;

`ifdef RSTSEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYC + 1);
    localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYC);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);

    logic [WW-1:0] wdt_q, wdt_d;
    logic          fault_q, fault_d;
    logic [IW-1:0] fstage_q, fstage_d;

    // Counts cycles since the current stage's RELEASE (RELEASE itself is 1).
    always_comb begin
        wdt_d = wdt_q;
        if (state_q == RELEASE) begin
            wdt_d = WW'(1);
        end else if ((state_q == HOLD || state_q == WAIT_RDY) && wdt_q != WDT_MAX) begin
            wdt_d = wdt_q + 1'b1;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt = (WDT_CYC == 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        rstn_d  = rstn_q;
`ifdef RSTSEQ_WATCHDOG_EN
        fault_d  = fault_q;
        fstage_d = fstage_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                if (sw_rst_req) begin
                    state_d = TEARDOWN;
                end else if (lock_ok) begin
                    state_d = RELEASE;
                    idx_d   = '0;
                end
            end
            RELEASE: begin
                if (abort_req) begin
                    state_d = TEARDOWN;
                end else begin
                    rstn_d[idx_q] = 1'b1;
                    dly_d         = '0;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (abort_req) begin
                    state_d = TEARDOWN;
                end else if (dly_q == DLY_LAST) begin
                    state_d = WAIT_RDY;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (abort_req) begin
                    state_d = TEARDOWN;
                end else if (stage_ready[idx_q]) begin
                    if (idx_q == LAST_STAGE) begin
                        state_d = RUN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RELEASE;
                    end
                end
`ifdef RSTSEQ_WATCHDOG_EN
                else if (wdt_q >= WDT_LAST) begin
                    state_d  = FAULT;
                    rstn_d   = '0;
                    fault_d  = 1'b1;
                    fstage_d = idx_q;
                end
`endif
            end
            RUN: begin
                if (abort_req) begin
                    state_d = TEARDOWN;
                end
            end
            TEARDOWN: begin
                // Released stages are always a contiguous run from bit 0, so a
                // right shift drops exactly the highest released stage.
                rstn_d = rstn_q >> 1;
                if ((rstn_q >> 1) == '0) begin
                    state_d = WAIT_LOCK;
                end
            end
            FAULT: begin
                rstn_d = '0;
                if (sw_rst_req) begin
                    state_d = WAIT_LOCK;
`ifdef RSTSEQ_WATCHDOG_EN
                    fault_d  = 1'b0;
                    fstage_d = '0;
`endif
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                rstn_d  = '0;
            end
        endcase
        all_up_d = (state_d == RUN);
    end

    always_ff @(posedge clk_100M) begin
        if (!sysrstn) begin
            state_q  <= WAIT_LOCK;
            idx_q    <= '0;
            dly_q    <= '0;
            rstn_q   <= '0;
            all_up_q <= 1'b0;
`ifdef RSTSEQ_WATCHDOG_EN
            wdt_q    <= '0;
            fault_q  <= 1'b0;
            fstage_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dly_q    <= dly_d;
            rstn_q   <= rstn_d;
            all_up_q <= all_up_d;
`ifdef RSTSEQ_WATCHDOG_EN
            wdt_q    <= wdt_d;
            fault_q  <= fault_d;
            fstage_q <= fstage_d;
`endif
        end
    end

    assign stage_rstn = rstn_q;
    assign all_up     = all_up_q;
    assign seq_state  = state_q;
`ifdef RSTSEQ_WATCHDOG_EN
    assign fault       = fault_q;
    assign fault_stage = fstage_q;
`else
    assign fault       = 1'b0;
    assign fault_stage = '0;
`endif

endmodule

// File: tb/tb_rover_reset_sequencer.sv
// Directed bench for rover_reset_sequencer (NUM_STAGES=4, LOCK_FILTER_CYC=16,
// STAGE_DELAY_CYC=8, WDT_CYC=64). Outputs sampled 1 time unit after each edge.
module tb_rover_reset_sequencer;

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_RELEASE   = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_WAIT_RDY  = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_TEARDOWN  = 3'd5;
`ifdef RSTSEQ_WATCHDOG_EN
    localparam logic [2:0] S_FAULT     = 3'd6;
`endif

    logic       clk_100M = 1'b0;
    logic       sysrstn;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [3:0] stage_ready;
    logic [3:0] stage_rstn;
    logic       all_up;
    logic       fault;
    logic [1:0] fault_stage;
    logic [2:0] seq_state;

    int checks = 0;
    int passes = 0;

    rover_reset_sequencer #(
        .NUM_STAGES      (4),
        .LOCK_FILTER_CYC (16),
        .STAGE_DELAY_CYC (8),
        .WDT_CYC         (64)
    ) dut (
        .clk_100M    (clk_100M),
        .sysrstn     (sysrstn),
        .pll_locked  (pll_locked),
        .sw_rst_req  (sw_rst_req),
        .stage_ready (stage_ready),
        .stage_rstn  (stage_rstn),
        .all_up      (all_up),
        .fault       (fault),
        .fault_stage (fault_stage),
        .seq_state   (seq_state)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic step(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [3:0] rstn, input logic up);
        chk({tag, ".state"}, 32'(seq_state), 32'(st));
        chk({tag, ".rstn"},  32'(stage_rstn), 32'(rstn));
        chk({tag, ".all_up"}, 32'(all_up), 32'(up));
    endtask

    initial begin
        sysrstn = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0; stage_ready = 4'b1111;
        step(1);
        chk_st("reset", S_WAIT_LOCK, 4'b0000, 1'b0);
        chk("reset.fault", 32'(fault), 32'd0);
        chk("reset.fstage", 32'(fault_stage), 32'd0);
        sysrstn = 1'b1;

        // 1: nominal sequence, ready already high during HOLD
        step(16); chk_st("nom.filter", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("nom.rel0", S_RELEASE, 4'b0000, 1'b0);
        step(1);  chk_st("nom.hold0", S_HOLD, 4'b0001, 1'b0);
        step(9);  chk_st("nom.rel1", S_RELEASE, 4'b0001, 1'b0);
        step(1);  chk_st("nom.s1", S_HOLD, 4'b0011, 1'b0);
        step(10); chk_st("nom.s2", S_HOLD, 4'b0111, 1'b0);
        step(10); chk_st("nom.s3", S_HOLD, 4'b1111, 1'b0);
        step(8);  chk_st("nom.wrdy3", S_WAIT_RDY, 4'b1111, 1'b0);
        step(1);  chk_st("nom.run", S_RUN, 4'b1111, 1'b1);
        stage_ready = 4'b0000;
        step(3);  chk_st("run.rdy_drop", S_RUN, 4'b1111, 1'b1);
        stage_ready = 4'b1111;

        // 3: lock loss in RUN; sw request during TEARDOWN ignored
        pll_locked = 1'b0;
        step(1);  chk_st("loss.entry", S_TEARDOWN, 4'b1111, 1'b0);
        sw_rst_req = 1'b1;
        step(1);  chk_st("loss.t1", S_TEARDOWN, 4'b0111, 1'b0);
        sw_rst_req = 1'b0;
        step(1);  chk_st("loss.t2", S_TEARDOWN, 4'b0011, 1'b0);
        step(1);  chk_st("loss.t3", S_TEARDOWN, 4'b0001, 1'b0);
        step(1);  chk_st("loss.done", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("loss.stay", S_WAIT_LOCK, 4'b0000, 1'b0);

        // 2: glitchy lock restarts the filter
        pll_locked = 1'b1; step(15);
        pll_locked = 1'b0; step(1);
        pll_locked = 1'b1;
        step(16); chk_st("glitch.filter", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("glitch.rel0", S_RELEASE, 4'b0000, 1'b0);

        // 4: sw request during HOLD of stage 2
        step(21); chk_st("sw.hold2", S_HOLD, 4'b0111, 1'b0);
        step(2);
        sw_rst_req = 1'b1;
        step(1);  chk_st("sw.entry", S_TEARDOWN, 4'b0111, 1'b0);
        sw_rst_req = 1'b0;
        step(1);  chk_st("sw.t1", S_TEARDOWN, 4'b0011, 1'b0);
        step(1);  chk_st("sw.t2", S_TEARDOWN, 4'b0001, 1'b0);
        step(1);  chk_st("sw.done", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(16); chk_st("sw.refilter", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("sw.rel0", S_RELEASE, 4'b0000, 1'b0);
        step(1);  chk_st("sw.hold0", S_HOLD, 4'b0001, 1'b0);

        // sw request plus lock loss together: one pass
        sw_rst_req = 1'b1; pll_locked = 1'b0;
        step(1);  chk_st("both.entry", S_TEARDOWN, 4'b0001, 1'b0);
        sw_rst_req = 1'b0;
        step(1);  chk_st("both.done", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("both.single", S_WAIT_LOCK, 4'b0000, 1'b0);

        // 6: sysrstn pulse mid-RUN
        pll_locked = 1'b1;
        step(17); chk_st("rst.rel0", S_RELEASE, 4'b0000, 1'b0);
        step(40); chk_st("rst.run", S_RUN, 4'b1111, 1'b1);
        sysrstn = 1'b0;
        step(1);  chk_st("rst.edge", S_WAIT_LOCK, 4'b0000, 1'b0);
        chk("rst.fault", 32'(fault), 32'd0);
        sysrstn = 1'b1;
        step(16); chk_st("rst.filter", S_WAIT_LOCK, 4'b0000, 1'b0);
        step(1);  chk_st("rst.rel0b", S_RELEASE, 4'b0000, 1'b0);

        // 5: stage 1 never becomes ready
        stage_ready = 4'b0001;
        step(10); chk_st("wdt.rel1", S_RELEASE, 4'b0001, 1'b0);
        step(63); chk_st("wdt.pre", S_WAIT_RDY, 4'b0011, 1'b0);
        chk("wdt.pre.fault", 32'(fault), 32'd0);
        step(1);
`ifdef RSTSEQ_WATCHDOG_EN
        chk_st("wdt.fault", S_FAULT, 4'b0000, 1'b0);
        chk("wdt.fault.flag", 32'(fault), 32'd1);
        chk("wdt.fault.stage", 32'(fault_stage), 32'd1);
        step(5);  chk_st("wdt.stay", S_FAULT, 4'b0000, 1'b0);
        sw_rst_req = 1'b1;
        step(1);  chk_st("wdt.clear", S_WAIT_LOCK, 4'b0000, 1'b0);
        chk("wdt.clear.flag", 32'(fault), 32'd0);
        sw_rst_req = 1'b0;
`else
        chk_st("wdt.off", S_WAIT_RDY, 4'b0011, 1'b0);
        chk("wdt.off.fault", 32'(fault), 32'd0);
        step(100); chk_st("wdt.off.wait", S_WAIT_RDY, 4'b0011, 1'b0);
        chk("wdt.off.fstage", 32'(fault_stage), 32'd0);
        sw_rst_req = 1'b1;
        step(1);  chk_st("wdt.off.sw", S_TEARDOWN, 4'b0011, 1'b0);
        sw_rst_req = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
